// File: rtl/collision_check_scheduler_if.sv
// rtl/collision_check_scheduler_if.sv - car request/operand buses, checker operands and per-car results
// The scheduler takes the slave side; cars plus the checker form the master side.
interface collision_check_scheduler_if #(
   parameter int NUM_PLAYERS = 4,
   parameter int X_WIDTH     = 12,
   parameter int Y_WIDTH     = 11,
   parameter int V_WIDTH     = 16,
   parameter int R_WIDTH     = 10
);
   logic [NUM_PLAYERS-1:0]         i_req;
   logic [NUM_PLAYERS*X_WIDTH-1:0] i_x;
   logic [NUM_PLAYERS*Y_WIDTH-1:0] i_y;
   logic [NUM_PLAYERS*V_WIDTH-1:0] i_v_x;
   logic [NUM_PLAYERS*V_WIDTH-1:0] i_v_y;
   logic [NUM_PLAYERS*R_WIDTH-1:0] i_radius;
   logic                           i_frame_clr;
   logic [X_WIDTH-1:0]             o_chk_x;
   logic [Y_WIDTH-1:0]             o_chk_y;
   logic [V_WIDTH-1:0]             o_chk_v_x;
   logic [V_WIDTH-1:0]             o_chk_v_y;
   logic [R_WIDTH-1:0]             o_chk_radius;
   logic                           i_chk_collision;
   logic [NUM_PLAYERS-1:0]         o_grant;
   logic [NUM_PLAYERS-1:0]         o_ack;
   logic                           o_hit;
   logic [NUM_PLAYERS-1:0]         o_hit_vec;
   logic                           o_busy;

   modport slave (
      input  i_req, i_x, i_y, i_v_x, i_v_y, i_radius, i_frame_clr, i_chk_collision,
      output o_chk_x, o_chk_y, o_chk_v_x, o_chk_v_y, o_chk_radius,
      output o_grant, o_ack, o_hit, o_hit_vec, o_busy
   );

   modport master (
      output i_req, i_x, i_y, i_v_x, i_v_y, i_radius, i_frame_clr, i_chk_collision,
      input  o_chk_x, o_chk_y, o_chk_v_x, o_chk_v_y, o_chk_radius,
      input  o_grant, o_ack, o_hit, o_hit_vec, o_busy
   );
endinterface

// File: rtl/collision_check_scheduler.sv
// rtl/collision_check_scheduler.sv - round-robin time-sharing of one collision checker among cars
// Serves one car per IDLE->WAIT->RESP pass; operands pass through unmodified.
module collision_check_scheduler #(
   parameter int NUM_PLAYERS = 4,
   parameter int X_WIDTH     = 12,
   parameter int Y_WIDTH     = 11,
   parameter int V_WIDTH     = 16,
   parameter int R_WIDTH     = 10,
   parameter int CHK_LATENCY = 0
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   collision_check_scheduler_if.slave bus
);
   localparam int PTR_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int CNT_W = (CHK_LATENCY > 0) ? $clog2(CHK_LATENCY + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                 state;
   state_t                 state_n;
   logic [NUM_PLAYERS-1:0] pend;
   logic [NUM_PLAYERS-1:0] grant_v;
   logic [NUM_PLAYERS-1:0] ack_v;
   logic [NUM_PLAYERS-1:0] hit_vec;
   logic [PTR_W-1:0]       ptr;
   logic [PTR_W-1:0]       sel;
   logic [PTR_W-1:0]       pick;
   logic [PTR_W:0]         cand;
   logic                   found;
   logic [CNT_W-1:0]       cnt;
   logic                   hit_r;

   logic [X_WIDTH-1:0]     chk_x,  pick_x;
   logic [Y_WIDTH-1:0]     chk_y,  pick_y;
   logic [V_WIDTH-1:0]     chk_vx, pick_vx;
   logic [V_WIDTH-1:0]     chk_vy, pick_vy;
   logic [R_WIDTH-1:0]     chk_r,  pick_r;

   // First pending car at or after ptr, wrapping past the last car.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         cand = {1'b0, ptr} + (PTR_W+1)'(i);
         if (cand >= (PTR_W+1)'(NUM_PLAYERS)) begin
            cand = cand - (PTR_W+1)'(NUM_PLAYERS);
         end
         if (!found && pend[cand[PTR_W-1:0]]) begin
            found = 1'b1;
            pick  = cand[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      pick_x  = '0;
      pick_y  = '0;
      pick_vx = '0;
      pick_vy = '0;
      pick_r  = '0;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
         if (pick == PTR_W'(k)) begin
            pick_x  = bus.i_x[k*X_WIDTH +: X_WIDTH];
            pick_y  = bus.i_y[k*Y_WIDTH +: Y_WIDTH];
            pick_vx = bus.i_v_x[k*V_WIDTH +: V_WIDTH];
            pick_vy = bus.i_v_y[k*V_WIDTH +: V_WIDTH];
            pick_r  = bus.i_radius[k*R_WIDTH +: R_WIDTH];
         end
      end
   end

   always_comb begin
      state_n = state;
      grant_v = '0;
      ack_v   = '0;
      case (state)
         S_IDLE: begin
            if (found) begin
               grant_v[pick] = 1'b1;
               state_n       = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == '0) begin
               state_n = S_RESP;
            end
         end
         S_RESP: begin
            ack_v[sel] = 1'b1;
            state_n    = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state   <= S_IDLE;
         pend    <= '0;
         ptr     <= '0;
         sel     <= '0;
         cnt     <= '0;
         hit_r   <= 1'b0;
         hit_vec <= '0;
         chk_x   <= '0;
         chk_y   <= '0;
         chk_vx  <= '0;
         chk_vy  <= '0;
         chk_r   <= '0;
      end else begin
         state <= state_n;
         // A fresh pulse on the granted car re-arms its pending bit.
         pend  <= (pend & ~grant_v) | bus.i_req;
         if (state == S_IDLE && found) begin
            sel    <= pick;
            cnt    <= CNT_W'(CHK_LATENCY);
            chk_x  <= pick_x;
            chk_y  <= pick_y;
            chk_vx <= pick_vx;
            chk_vy <= pick_vy;
            chk_r  <= pick_r;
         end
         if (state == S_WAIT) begin
            if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end else begin
               hit_r <= bus.i_chk_collision;
            end
         end
         if (state == S_RESP) begin
            ptr <= (sel == PTR_W'(NUM_PLAYERS - 1)) ? '0 : sel + 1'b1;
         end
         // A hit landing with a frame clear survives the clear.
         hit_vec <= (bus.i_frame_clr ? '0 : hit_vec) | (hit_r ? ack_v : '0);
      end
   end

   assign bus.o_chk_x      = chk_x;
   assign bus.o_chk_y      = chk_y;
   assign bus.o_chk_v_x    = chk_vx;
   assign bus.o_chk_v_y    = chk_vy;
   assign bus.o_chk_radius = chk_r;
   assign bus.o_grant      = grant_v;
   assign bus.o_ack        = ack_v;
   assign bus.o_hit        = (state == S_RESP) && hit_r;
   assign bus.o_hit_vec    = hit_vec;
   assign bus.o_busy       = (state != S_IDLE);
endmodule

// File: tb/tb_collision_check_scheduler.sv
// tb/tb_collision_check_scheduler.sv - directed checks on three scheduler instances (checker latency 0, 2, 3)
// Stub checker reports collision = o_chk_x[0] delayed by the instance latency.
module tb_collision_check_scheduler;
   logic clk = 1'b0;
   logic rst_n;
   logic rst_c;
   logic frame_clr;
   logic [47:0] x_bus;
   logic [43:0] y_bus;
   logic [63:0] vx_bus;
   logic [63:0] vy_bus;
   logic [39:0] r_bus;
   logic b_d1, b_d2;
   logic c_d1, c_d2, c_d3;
   logic saw;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   collision_check_scheduler_if #(.NUM_PLAYERS(4), .X_WIDTH(12), .Y_WIDTH(11), .V_WIDTH(16), .R_WIDTH(10)) bus_a ();
   collision_check_scheduler_if #(.NUM_PLAYERS(4), .X_WIDTH(12), .Y_WIDTH(11), .V_WIDTH(16), .R_WIDTH(10)) bus_b ();
   collision_check_scheduler_if #(.NUM_PLAYERS(4), .X_WIDTH(12), .Y_WIDTH(11), .V_WIDTH(16), .R_WIDTH(10)) bus_c ();

   collision_check_scheduler #(.NUM_PLAYERS(4), .X_WIDTH(12), .Y_WIDTH(11), .V_WIDTH(16), .R_WIDTH(10), .CHK_LATENCY(0))
      u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
   collision_check_scheduler #(.NUM_PLAYERS(4), .X_WIDTH(12), .Y_WIDTH(11), .V_WIDTH(16), .R_WIDTH(10), .CHK_LATENCY(2))
      u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));
   collision_check_scheduler #(.NUM_PLAYERS(4), .X_WIDTH(12), .Y_WIDTH(11), .V_WIDTH(16), .R_WIDTH(10), .CHK_LATENCY(3))
      u_c (.i_clk(clk), .i_rst_n(rst_c), .bus(bus_c));

   assign bus_a.i_x = x_bus;  assign bus_b.i_x = x_bus;  assign bus_c.i_x = x_bus;
   assign bus_a.i_y = y_bus;  assign bus_b.i_y = y_bus;  assign bus_c.i_y = y_bus;
   assign bus_a.i_v_x = vx_bus;  assign bus_b.i_v_x = vx_bus;  assign bus_c.i_v_x = vx_bus;
   assign bus_a.i_v_y = vy_bus;  assign bus_b.i_v_y = vy_bus;  assign bus_c.i_v_y = vy_bus;
   assign bus_a.i_radius = r_bus;  assign bus_b.i_radius = r_bus;  assign bus_c.i_radius = r_bus;
   assign bus_a.i_frame_clr = frame_clr;
   assign bus_b.i_frame_clr = frame_clr;
   assign bus_c.i_frame_clr = frame_clr;

   assign bus_a.i_chk_collision = bus_a.o_chk_x[0];
   always @(posedge clk) begin
      b_d1 <= bus_b.o_chk_x[0];
      b_d2 <= b_d1;
      c_d1 <= bus_c.o_chk_x[0];
      c_d2 <= c_d1;
      c_d3 <= c_d2;
   end
   assign bus_b.i_chk_collision = b_d2;
   assign bus_c.i_chk_collision = c_d3;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_x(input logic [11:0] x0, input logic [11:0] x1, input logic [11:0] x2, input logic [11:0] x3);
      x_bus = {x3, x2, x1, x0};
   endtask

   initial begin
      rst_n = 1'b0;
      rst_c = 1'b0;
      frame_clr = 1'b0;
      bus_a.i_req = '0;
      bus_b.i_req = '0;
      bus_c.i_req = '0;
      x_bus  = '0;
      y_bus  = {11'd0, 11'd0, 11'h400, 11'd0};
      vx_bus = {16'd0, 16'd0, 16'h8001, 16'd0};
      vy_bus = {16'd0, 16'd0, 16'h7fff, 16'd0};
      r_bus  = {10'd0, 10'd0, 10'h3ff, 10'd0};
      step();
      step();
      check("rst_busy", bus_a.o_busy, 0);
      check("rst_grant", bus_a.o_grant, 0);
      check("rst_ack", bus_a.o_ack, 0);
      check("rst_hit", bus_a.o_hit, 0);
      check("rst_hit_vec", bus_a.o_hit_vec, 0);
      check("rst_chk_x", bus_a.o_chk_x, 0);
      rst_n = 1'b1;
      rst_c = 1'b1;
      step();

      // single request, latency 2
      set_x(12'd0, 12'd13, 12'd0, 12'd0);
      bus_b.i_req = 4'b0010;
      step();
      check("single_grant", bus_b.o_grant, 4'b0010);
      bus_b.i_req = '0;
      step();
      check("single_chk_x", bus_b.o_chk_x, 13);
      check("single_chk_y", bus_b.o_chk_y, 32'h400);
      check("single_chk_vx", bus_b.o_chk_v_x, 32'h8001);
      check("single_chk_vy", bus_b.o_chk_v_y, 32'h7fff);
      check("single_chk_r", bus_b.o_chk_radius, 32'h3ff);
      check("single_busy", bus_b.o_busy, 1);
      step();
      step();
      check("single_no_early_ack", bus_b.o_ack, 0);
      step();
      check("single_ack", bus_b.o_ack, 4'b0010);
      check("single_hit", bus_b.o_hit, 1);
      step();
      check("single_hit_vec", bus_b.o_hit_vec, 4'b0010);
      check("single_hit_low", bus_b.o_hit, 0);
      check("single_idle", bus_b.o_busy, 0);
      check("single_chk_x_hold", bus_b.o_chk_x, 13);

      // round robin, latency 0: cars 1 and 3 have odd x
      set_x(12'd2, 12'd13, 12'd4, 12'd7);
      bus_a.i_req = 4'b1111;
      step();
      bus_a.i_req = '0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rr_grant%0d", k), bus_a.o_grant, 32'(1 << k));
         step();
         step();
         check($sformatf("rr_ack%0d", k), bus_a.o_ack, 32'(1 << k));
         check($sformatf("rr_hit%0d", k), bus_a.o_hit, (k % 2 == 1) ? 1 : 0);
         step();
      end
      check("rr_idle", bus_a.o_busy, 0);
      check("rr_hit_vec", bus_a.o_hit_vec, 4'b1010);
      bus_a.i_req = 4'b1111;
      step();
      check("rr_wrap_grant", bus_a.o_grant, 4'b0001);
      bus_a.i_req = '0;
      repeat (12) step();
      check("rr_wrap_idle", bus_a.o_busy, 0);

      // fairness: car 0 beats car 2's re-request
      bus_a.i_req = 4'b0100;
      step();
      check("fair_grant2", bus_a.o_grant, 4'b0100);
      bus_a.i_req = 4'b0001;
      step();
      bus_a.i_req = '0;
      step();
      check("fair_ack2", bus_a.o_ack, 4'b0100);
      bus_a.i_req = 4'b0100;
      step();
      check("fair_grant0", bus_a.o_grant, 4'b0001);
      bus_a.i_req = '0;
      step();
      step();
      check("fair_ack0", bus_a.o_ack, 4'b0001);
      step();
      check("fair_grant2_again", bus_a.o_grant, 4'b0100);
      step();
      step();
      check("fair_ack2_again", bus_a.o_ack, 4'b0100);
      step();

      // requeue: pulse car 1 in its own grant cycle
      bus_a.i_req = 4'b0010;
      step();
      check("requeue_grant1", bus_a.o_grant, 4'b0010);
      step();
      bus_a.i_req = '0;
      step();
      check("requeue_ack1", bus_a.o_ack, 4'b0010);
      step();
      check("requeue_grant2", bus_a.o_grant, 4'b0010);
      step();
      step();
      check("requeue_ack2", bus_a.o_ack, 4'b0010);
      step();
      check("requeue_idle", bus_a.o_busy, 0);
      check("requeue_no_third", bus_a.o_grant, 0);

      // frame clear racing a hit on car 3
      frame_clr = 1'b1;
      step();
      frame_clr = 1'b0;
      check("fc_cleared", bus_a.o_hit_vec, 0);
      set_x(12'd1, 12'd0, 12'd3, 12'd5);
      bus_a.i_req = 4'b0101;
      step();
      bus_a.i_req = '0;
      check("fc_grant_car2_first", bus_a.o_grant, 4'b0100);
      repeat (6) step();
      check("fc_hit_vec_0101", bus_a.o_hit_vec, 4'b0101);
      bus_a.i_req = 4'b1000;
      step();
      bus_a.i_req = '0;
      check("fc_grant3", bus_a.o_grant, 4'b1000);
      step();
      step();
      check("fc_ack3", bus_a.o_ack, 4'b1000);
      check("fc_hit3", bus_a.o_hit, 1);
      frame_clr = 1'b1;
      step();
      frame_clr = 1'b0;
      check("fc_set_wins", bus_a.o_hit_vec, 4'b1000);

      // latency 3: full service, then reset two cycles after a grant
      set_x(12'd1, 12'd0, 12'd0, 12'd0);
      bus_c.i_req = 4'b0001;
      step();
      bus_c.i_req = '0;
      check("c_grant", bus_c.o_grant, 4'b0001);
      repeat (4) step();
      check("c_no_early_ack", bus_c.o_ack, 0);
      step();
      check("c_ack", bus_c.o_ack, 4'b0001);
      step();
      check("c_hit_vec", bus_c.o_hit_vec, 4'b0001);
      bus_c.i_req = 4'b0001;
      step();
      bus_c.i_req = '0;
      check("c_grant_again", bus_c.o_grant, 4'b0001);
      step();
      step();
      rst_c = 1'b0;
      bus_c.i_req = 4'b0010;
      step();
      rst_c = 1'b1;
      bus_c.i_req = '0;
      check("c_rst_busy", bus_c.o_busy, 0);
      check("c_rst_pend", bus_c.o_grant, 0);
      check("c_rst_hit_vec", bus_c.o_hit_vec, 0);
      check("c_rst_chk_x", bus_c.o_chk_x, 0);
      saw = 1'b0;
      repeat (8) begin
         step();
         if (bus_c.o_ack != 0 || bus_c.o_grant != 0) saw = 1'b1;
      end
      check("c_no_ack_after_rst", saw, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/collision_check_scheduler.md
Name: collision_check_scheduler

Overview:
- Time-shares one track-collision checker (x, y, vx, vy, radius in; single collision flag out) among NUM_PLAYERS cars in the game-control path.
- Each car's physics unit posts a request pulse.
- The scheduler round-robin grants one car at a time and drives the checker operands from that car's live buses.
- After a fixed checker latency it returns a per-car ack pulse, a hit flag, and a sticky per-car hit vector for the frame.

Parameters:
- NUM_PLAYERS, 4: number of requesting cars (2..8).
- X_WIDTH, 12: signed map x width.
- Y_WIDTH, 11: signed map y width.
- V_WIDTH, 16: signed fixed-point velocity width (integer + fraction).
- R_WIDTH, 10: signed radius width.
- CHK_LATENCY, 0: checker pipeline depth in cycles (0 means combinational).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_req  in  NUM_PLAYERS  per-car one-cycle request pulse
- i_x  in  NUM_PLAYERS*X_WIDTH  packed car x, car k at [k*X_WIDTH +: X_WIDTH]
- i_y  in  NUM_PLAYERS*Y_WIDTH  packed car y
- i_v_x  in  NUM_PLAYERS*V_WIDTH  packed car vx
- i_v_y  in  NUM_PLAYERS*V_WIDTH  packed car vy
- i_radius  in  NUM_PLAYERS*R_WIDTH  packed car radius
- i_frame_clr  in  1  pulse; clears o_hit_vec
- o_chk_x  out  X_WIDTH  checker x operand (registered)
- o_chk_y  out  Y_WIDTH  checker y operand
- o_chk_v_x  out  V_WIDTH  checker vx operand
- o_chk_v_y  out  V_WIDTH  checker vy operand
- o_chk_radius  out  R_WIDTH  checker radius operand
- i_chk_collision  in  1  checker result, valid CHK_LATENCY cycles after operands change
- o_grant  out  NUM_PLAYERS  one-hot, one-cycle pulse on operand capture
- o_ack  out  NUM_PLAYERS  one-hot, one-cycle pulse when the result is ready
- o_hit  out  1  result for the acked car; valid only while o_ack is nonzero
- o_hit_vec  out  NUM_PLAYERS  sticky OR of hits since the last i_frame_clr
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (i_rst_n=0 at an edge) clears:
  - all outputs, pending bits and operand registers to 0;
  - round-robin pointer to 0;
  - state to IDLE.
- Reset mid-service drops the request in flight with no ack.
- Pending: an i_req[k] pulse sets pend[k]. A pulse while pend[k] is already set merges into it.
- Grant/clear collision: if pend[k] is granted in the same cycle i_req[k] pulses, pend[k] stays set, so a new request is queued.
- Operand stability: car k must hold its operands stable from its req pulse until its o_ack.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, pend==0: stay in IDLE.
  - IDLE, pend!=0: select the first set pend bit searching from ptr upward with wrap. In that cycle:
    - assert o_grant[sel];
    - clear pend[sel];
    - register car sel's operands into o_chk_*;
    - load cnt=CHK_LATENCY;
    - go to WAIT.
  - WAIT: operands on o_chk_* are stable. If cnt!=0, decrement it. If cnt==0, capture i_chk_collision into a hit register and go to RESP. WAIT therefore lasts CHK_LATENCY+1 cycles.
  - RESP: assert o_ack[sel]=1 and o_hit=captured value, and OR the hit into o_hit_vec[sel]. Set ptr=(sel+1) mod NUM_PLAYERS, then go to IDLE.
- Timing:
  - Req pulse at cycle t → grant at t+1 (if IDLE) → ack at t+CHK_LATENCY+3.
  - Service period is CHK_LATENCY+3 cycles per car.
  - A car's worst-case wait is NUM_PLAYERS service periods.
- o_chk_* hold their last value outside service; the checker is don't-care then.
- o_hit is 0 whenever o_ack==0.
- Frame clear: i_frame_clr clears o_hit_vec. If it coincides with a RESP hit, the set wins for that bit.
- No operand arithmetic: fields are sliced and passed through with width preserved and sign bits untouched.

Test Plan:
- Single request: stub checker returns collision = o_chk_x[0] delayed CHK_LATENCY. With CHK_LATENCY=2, pulse i_req=4'b0010 at cycle 10 with car1 x=13 → o_grant=0010 at 11, o_chk_x=13 from 12, o_ack=0010 with o_hit=1 at 15, o_hit_vec=0010.
- Round robin: CHK_LATENCY=0, pulse i_req=4'b1111 at cycle 5 → grants to cars 0,1,2,3 at cycles 6,9,12,15 and acks at 8,11,14,17. Then pulse 1111 again → next grant goes to car 0 again (ptr wrapped).
- Fairness: car 2 re-requests every ack while car 0 requests once at cycle 7 → car 0 is granted before car 2's second service.
- Requeue collision: pulse i_req[1] in the cycle car 1 is granted → car 1 is serviced twice, two acks, second grant 3 cycles after the first with CHK_LATENCY=0.
- Reset mid-WAIT: CHK_LATENCY=3, deassert i_rst_n for one edge at grant+2 → no ack; o_busy=0, pend=0, o_hit_vec=0 the next cycle.
- Frame clear: o_hit_vec=0101, then i_frame_clr coincides with RESP hit for car 3 → o_hit_vec=1000.
